// File: rtl/mem_access_stage.sv
// MEM stage: load formatting, store drive, MEM/WB register and a debug word-read port that the pipeline pre-empts.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [1:0]                i_width,
    input  logic                      i_unsigned,
    input  logic [31:0]               i_addr,
    input  logic [DATA_WIDTH*4-1:0]   i_store_data,
    input  logic [DATA_WIDTH*4-1:0]   i_alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                      i_reg_write,
    output logic                      o_ready,
    output logic                      o_ram_we,
    output logic [1:0]                o_ram_width,
    output logic [ADDR_WIDTH-1:0]     o_ram_addr,
    output logic [DATA_WIDTH*4-1:0]   o_ram_data,
    input  logic [DATA_WIDTH*4-1:0]   i_ram_data,
    input  logic                      i_dbg_req,
    input  logic [ADDR_WIDTH-1:0]     i_dbg_addr,
    output logic                      o_dbg_ack,
    output logic [DATA_WIDTH*4-1:0]   o_dbg_data,
    output logic                      o_valid,
    output logic [DATA_WIDTH*4-1:0]   o_wb_data,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic                      o_reg_write,
    output logic                      o_misaligned
);

    localparam int WORD_WIDTH = DATA_WIDTH * 4;
    localparam int HALF_WIDTH = DATA_WIDTH * 2;

    localparam logic [1:0] WIDTH_BYTE    = 2'b00;
    localparam logic [1:0] WIDTH_HALF    = 2'b01;
    localparam logic [1:0] WIDTH_ILLEGAL = 2'b10;
    localparam logic [1:0] WIDTH_WORD    = 2'b11;

    typedef enum logic {ST_RUN = 1'b0, ST_DBG = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic                      valid_q, valid_d;
    logic [WORD_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      reg_write_q, reg_write_d;
    logic                      misaligned_q, misaligned_d;
    logic                      dbg_ack_q, dbg_ack_d;
    logic [WORD_WIDTH-1:0]     dbg_data_q, dbg_data_d;

    logic                      accept;
    logic                      legal_width;
    logic                      misaligned;
    logic                      trap;
    logic [WORD_WIDTH-1:0]     load_data;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((i_width == WIDTH_HALF) && i_addr[0]) ||
                        ((i_width == WIDTH_WORD) && (i_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign o_ready     = (state_q == ST_RUN);
    assign o_ram_addr  = o_ready ? i_addr[ADDR_WIDTH-1:0] : i_dbg_addr;
    assign o_ram_width = i_width;
    assign o_ram_data  = i_store_data;

    assign accept      = i_valid & o_ready;
    assign legal_width = (i_width != WIDTH_ILLEGAL);
    assign trap        = accept & (i_mem_read | i_mem_write) & misaligned;
    assign o_ram_we    = accept & i_mem_write & ~i_mem_read & legal_width & ~misaligned;

    // Big-endian RAM: the addressed byte sits in the top lane of the read word.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_data = '0;
        case (i_width)
            WIDTH_BYTE: load_data = {{(WORD_WIDTH-DATA_WIDTH){~i_unsigned & i_ram_data[WORD_WIDTH-1]}},
                                     i_ram_data[WORD_WIDTH-1 -: DATA_WIDTH]};
            WIDTH_HALF: load_data = {{(WORD_WIDTH-HALF_WIDTH){~i_unsigned & i_ram_data[WORD_WIDTH-1]}},
                                     i_ram_data[WORD_WIDTH-1 -: HALF_WIDTH]};
            WIDTH_WORD: load_data = i_ram_data;
            default:    load_data = '0;
        endcase
    end

    // A level request is still high during its ack cycle; the ack guard keeps it from launching a second read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (i_dbg_req && !i_valid && !dbg_ack_q) state_d = ST_DBG;
            ST_DBG:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        valid_d      = accept;
        rd_d         = i_rd;
        reg_write_d  = i_reg_write & accept & ~trap;
        misaligned_d = trap;
        wb_data_d    = (i_valid && i_mem_read) ? load_data : i_alu_result;
        dbg_ack_d    = (state_q == ST_DBG);
        dbg_data_d   = (state_q == ST_DBG) ? i_ram_data : dbg_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_RUN;
            valid_q      <= 1'b0;
            wb_data_q    <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            misaligned_q <= 1'b0;
            dbg_ack_q    <= 1'b0;
            dbg_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            wb_data_q    <= wb_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            misaligned_q <= misaligned_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_data_q   <= dbg_data_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_wb_data    = wb_data_q;
    assign o_rd         = rd_q;
    assign o_reg_write  = reg_write_q;
    assign o_misaligned = misaligned_q;
    assign o_dbg_ack    = dbg_ack_q;
    assign o_dbg_data   = dbg_data_q;

endmodule
